// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (8N1 by default, LSB first).
// Start bit qualified at mid-bit, data and stop sampled mid-bit, one-cycle done/error pulses.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle; waiting for rx_s low (edge-driven, no tick needed)
// START  | counting to mid start bit; high there means glitch -> IDLE
// DATA   | sampling DATA_BITS data bits mid-bit, LSB first
// STOP   | sampling stop bit mid-bit; high -> rx_done, low -> frame_err
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                 rx_meta_q;
    logic                 rx_s_q;

    logic [1:0]           state_q,     state_d;
    logic [TW-1:0]        tick_cnt_q,  tick_cnt_d;
    logic [2:0]           bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] shift_in;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_done_q,   rx_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_busy_q,   rx_busy_d;

    // Synchroniser resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Right shift with the new bit entering at the MSB; written as a loop so DATA_BITS=1 stays legal.
    always_comb begin
        shift_in              = shift_q;
        shift_in[DATA_BITS-1] = rx_s_q;
        for (int i = 0; i < DATA_BITS - 1; i++) begin
            shift_in[i] = shift_q[i+1];
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_busy_d   = rx_busy_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d   = S_START;
                    rx_busy_d = 1'b1;
                end
            end

            S_START: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        if (!rx_s_q) begin
                            state_d    = S_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d   = S_IDLE;
                            rx_busy_d = 1'b0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        shift_d    = shift_in;
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        state_d    = S_IDLE;
                        rx_busy_d  = 1'b0;
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            rx_data_d = shift_q;
                            rx_done_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d   = S_IDLE;
                rx_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected outcomes, a monitor pops on each pulse.
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         busy_cnt = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-clock tick every 4 clocks, changed on the falling edge.
    initial begin
        int c;
        c = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = (c == 3);
            c = (c + 1) % 4;
        end
    end

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_busy) busy_cnt++;
            if (rx_done || frame_err) begin
                exp_t e;
                checks++;
                if (rx_done && frame_err) begin
                    errors++;
                    $display("FAIL pulse_excl: rx_done=%0b frame_err=%0b both high", rx_done, frame_err);
                end else if (prev_pulse) begin
                    errors++;
                    $display("FAIL pulse_width: pulse high on consecutive clocks");
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: rx_done=%0b frame_err=%0b rx_data=%02h, none expected",
                             rx_done, frame_err, rx_data);
                end else begin
                    e = sb.pop_front();
                    if (frame_err !== e.is_err || rx_data !== e.data || rx_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL frame: got err=%0b data=%02h busy=%0b, expected err=%0b data=%02h busy=0",
                                 frame_err, rx_data, rx_busy, e.is_err, e.data);
                    end
                end
            end
            prev_pulse = rx_done || frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick) k++;
        end
    endtask

    task automatic send_bit(input logic b, input int nticks);
        @(negedge clk);
        rx = b;
        wait_ticks(nticks);
    endtask

    // Good stop: full stop bit and a done expectation. Bad stop: short low stop so the
    // re-entered START sees high at its mid-point and aborts quietly.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        if (stop_ok) begin
            sb.push_back('{is_err: 1'b0, data: d});
            last_good = d;
        end else begin
            sb.push_back('{is_err: 1'b1, data: last_good});
        end
        send_bit(1'b0, OS);
        for (int i = 0; i < 8; i++) send_bit(d[i], OS);
        if (stop_ok) send_bit(1'b1, OS);
        else         send_bit(1'b0, 12);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        int b0;
        logic [7:0] r;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_done", rx_done, 0);
        check("reset_rx_busy", rx_busy, 0);
        check("reset_frame_err", frame_err, 0);
        rst_n = 1'b1;
        wait_ticks(2 * OS);

        // 1: single good frame
        send_frame(8'hA5, 1'b1);
        send_bit(1'b1, OS);
        drain("t1_drain");
        check("t1_rx_data", rx_data, 8'hA5);
        check("t1_busy_idle", rx_busy, 0);

        // 2: start glitch of 4 ticks
        b0 = busy_cnt;
        send_bit(1'b0, 4);
        send_bit(1'b1, 3 * OS);
        check("t2_busy_pulsed", (busy_cnt > b0) ? 1 : 0, 1);
        check("t2_busy_idle", rx_busy, 0);
        check("t2_rx_data_kept", rx_data, 8'hA5);

        // 3: bad stop bit
        send_frame(8'h3C, 1'b0);
        send_bit(1'b1, 3 * OS);
        drain("t3_drain");
        check("t3_rx_data_kept", rx_data, 8'hA5);
        check("t3_busy_idle", rx_busy, 0);

        // 4: back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1, OS);
        drain("t4_drain");
        check("t4_rx_data", rx_data, 8'hFF);

        // 5: reset during data bit 3 of 0x5A (bits LSB first: 0,1,0,1)
        send_bit(1'b0, OS);
        send_bit(1'b0, OS);
        send_bit(1'b1, OS);
        send_bit(1'b0, OS);
        send_bit(1'b1, OS / 2);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_rst_busy", rx_busy, 0);
        check("t5_rst_data", rx_data, 8'h00);
        rst_n = 1'b1;
        rx    = 1'b1;
        wait_ticks(2 * OS);
        check("t5_no_partial", sb.size(), 0);
        send_frame(8'h81, 1'b1);
        send_bit(1'b1, OS);
        drain("t5_drain");
        check("t5_rx_data", rx_data, 8'h81);

        // 6: bench transmitter on the same tick, random bytes back-to-back
        for (int i = 0; i < 32; i++) begin
            r = 8'($urandom_range(0, 255));
            send_frame(r, 1'b1);
        end
        send_bit(1'b1, OS);
        drain("t6_drain");
        check("t6_busy_idle", rx_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
